// File: rtl/jk_bank_arbiter_pkg.sv
// jk_bank_arbiter_pkg: shared op/state encodings for the JK bank arbiter.
package jk_bank_arbiter_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_HOLD = 2'b00;
   localparam op_t OP_CLR  = 2'b01;
   localparam op_t OP_SET  = 2'b10;
   localparam op_t OP_TGL  = 2'b11;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/jk_bank_arbiter_jkff.sv
// jk_ff: plain JK flip-flop without reset; {J,K} 00 hold, 01 clear, 10 set, 11 toggle.
module jk_ff (
   input  logic clk,
   input  logic J,
   input  logic K,
   output logic Q
);

   always_ff @(posedge clk)
      Q <= J ? (K ? ~Q : 1'b1) : (K ? 1'b0 : Q);

endmodule

// File: rtl/jk_bank_arbiter_rr.sv
// rr_arbiter: picks the first asserted request at or above ptr (mod N), one-hot plus index.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 any_o
);

   localparam int IW = $clog2(N);

   // Scan offsets high to low so the smallest offset from ptr wins.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[(int'(ptr_i) + k) % N]) begin
            idx_o = IW'((int'(ptr_i) + k) % N);
            any_o = 1'b1;
         end
      end
      gnt_o = any_o ? (N'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin shares a bank of jk_ff among NREQ masked-command requesters.
module jk_bank_arbiter
   import jk_bank_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [2*NREQ-1:0]        req_op,
   input  logic [WIDTH*NREQ-1:0]    req_mask,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     busy,
   output logic [WIDTH-1:0]         Q
);

   localparam int IW = $clog2(NREQ);

   state_e           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    gid_q, gid_d;
   op_t              op_q, op_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [NREQ-1:0]  gnt;
   logic [IW-1:0]    idx;
   logic             any;
   logic             accept;
   logic [WIDTH-1:0] j, k;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (idx),
      .any_o (any)
   );

   // The command register is not reset-gated: whatever it holds at the rst edge still lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         op_q    <= OP_CLR;
         mask_q  <= '1;
         ptr_q   <= '0;
         gid_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mask_q  <= mask_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
      end
   end

   always_comb begin
      state_d = (state_q == ST_INIT) ? ST_RUN : state_q;
      op_d    = accept ? req_op[2*int'(idx) +: 2] : OP_HOLD;
      mask_d  = accept ? req_mask[WIDTH*int'(idx) +: WIDTH] : '0;
      ptr_d   = accept ? ((idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1) : ptr_q;
      gid_d   = accept ? idx : gid_q;
   end

   always_comb begin
      req_ready = (state_q == ST_RUN) ? gnt : '0;
      accept    = (state_q == ST_RUN) & any;
      busy      = (state_q == ST_INIT);
   end

   assign grant_id = gid_q;
   assign j        = {WIDTH{op_q[1]}} & mask_q;
   assign k        = {WIDTH{op_q[0]}} & mask_q;

   for (genvar b = 0; b < WIDTH; b++) begin : g_bank
      jk_ff u_ff (
         .clk (clk),
         .J   (j[b]),
         .K   (k[b]),
         .Q   (Q[b])
      );
   end

endmodule
